// File: rtl/mdio_controller.sv
`default_nettype none
// ======================================================================
// mdio_controller : Clause 22 MDIO management master (STA side)
// Rev 1.0 - initial release
// ======================================================================
module mdio_controller #(
  parameter int MDC_HALF    = 1,
  parameter bit PREAMBLE_EN = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mdio_start,
  input  logic [31:0] t_data,
  input  logic        mdio_in,
  output logic        mdc,
  output logic        mdio_out,
  output logic        mdio_oe,
  output logic        busy,
  output logic [15:0] rd_data,
  output logic        data_rdy
);

  localparam int            HW       = (MDC_HALF > 1) ? $clog2(MDC_HALF) : 1;
  localparam logic [HW-1:0] HALF_MAX = HW'(MDC_HALF - 1);

  typedef enum logic [2:0] {
    IDLE, PREAMBLE, SHIFT_OUT, TURNAROUND, SHIFT_IN, DONE
  } state_t;

  state_t        state_q;
  logic [HW-1:0] half_cnt_q;
  logic [4:0]    bit_cnt_q;
  logic [31:0]   shift_out_q;
  logic [15:0]   shift_in_q;
  logic [15:0]   rd_data_q;
  logic          is_read_q;
  logic          mdc_q;
  logic          mdio_out_q;
  logic          mdio_oe_q;
  logic          busy_q;
  logic          data_rdy_q;

  logic half_end;
  logic out_last;

  assign half_end = (half_cnt_q == HALF_MAX);
  // Reads only drive ST/OP/PHYAD/REGAD (14 bits) before handing the line over.
  assign out_last = is_read_q ? (bit_cnt_q == 5'd13) : (bit_cnt_q == 5'd31);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      half_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_out_q <= '0;
      shift_in_q  <= '0;
      rd_data_q   <= '0;
      is_read_q   <= 1'b0;
      mdc_q       <= 1'b0;
      mdio_out_q  <= 1'b0;
      mdio_oe_q   <= 1'b0;
      busy_q      <= 1'b0;
      data_rdy_q  <= 1'b0;
    end else begin
      data_rdy_q <= 1'b0;
      if (state_q == IDLE) begin
        mdc_q      <= 1'b0;
        mdio_oe_q  <= 1'b0;
        mdio_out_q <= 1'b0;
        half_cnt_q <= '0;
        bit_cnt_q  <= '0;
        if (mdio_start) begin
          busy_q    <= 1'b1;
          mdio_oe_q <= 1'b1;
          is_read_q <= (t_data[29:28] == 2'b10);
          if (PREAMBLE_EN) begin
            state_q     <= PREAMBLE;
            mdio_out_q  <= 1'b1;
            shift_out_q <= t_data;
          end else begin
            state_q     <= SHIFT_OUT;
            mdio_out_q  <= t_data[31];
            shift_out_q <= {t_data[30:0], 1'b0};
          end
        end
      end else if (state_q == DONE) begin
        state_q <= IDLE;
      end else if (!half_end) begin
        half_cnt_q <= half_cnt_q + 1'b1;
      end else begin
        half_cnt_q <= '0;
        mdc_q      <= !mdc_q;
        if (!mdc_q) begin
          // Rising MDC: the peripheral's bit is captured here.
          if (state_q == SHIFT_IN) shift_in_q <= {shift_in_q[14:0], mdio_in};
        end else begin
          // Falling MDC closes a bit period; the next bit is presented now.
          bit_cnt_q <= bit_cnt_q + 1'b1;
          case (state_q)
            PREAMBLE: begin
              if (bit_cnt_q == 5'd31) begin
                state_q     <= SHIFT_OUT;
                bit_cnt_q   <= '0;
                mdio_out_q  <= shift_out_q[31];
                shift_out_q <= {shift_out_q[30:0], 1'b0};
              end
            end
            SHIFT_OUT: begin
              if (out_last) begin
                bit_cnt_q  <= '0;
                mdio_oe_q  <= 1'b0;
                mdio_out_q <= 1'b0;
                if (is_read_q) begin
                  state_q <= TURNAROUND;
                end else begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                end
              end else begin
                mdio_out_q  <= shift_out_q[31];
                shift_out_q <= {shift_out_q[30:0], 1'b0};
              end
            end
            TURNAROUND: begin
              if (bit_cnt_q == 5'd1) begin
                state_q   <= SHIFT_IN;
                bit_cnt_q <= '0;
              end
            end
            SHIFT_IN: begin
              if (bit_cnt_q == 5'd15) begin
                state_q    <= DONE;
                busy_q     <= 1'b0;
                rd_data_q  <= shift_in_q;
                data_rdy_q <= 1'b1;
              end
            end
            default: state_q <= IDLE;
          endcase
        end
      end
    end
  end

  assign mdc      = mdc_q;
  assign mdio_out = mdio_out_q;
  assign mdio_oe  = mdio_oe_q;
  assign busy     = busy_q;
  assign rd_data  = rd_data_q;
  assign data_rdy = data_rdy_q;

endmodule
`default_nettype wire
